// File: rtl/mult_pkg.sv
// mult_pkg: shared state type and default operand width for the sequential multiplier.
package mult_pkg;
    localparam int DEFAULT_WIDTH = 8;
    typedef enum logic [1:0] {IDLE, RUN, FINISH} state_e;
endpackage

// File: rtl/ripple_adder.sv
// ripple_adder: WIDTH-bit ripple-carry adder with carry-out, built from full-adder cells.
module ripple_adder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);
    logic [WIDTH:0] c;
    assign c[0] = 1'b0;
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign sum_o[i] = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    assign cout_o = c[WIDTH];
endmodule

// File: rtl/seq_array_multiplier.sv
// seq_array_multiplier: start/done shift-add multiplier, unsigned or signed, WIDTH+1 cycles per product.
module seq_array_multiplier
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               signed_mode_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [2*WIDTH-1:0] product_o
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] product_q, product_d;
    logic               neg_q, neg_d, done_q, done_d;
    logic [WIDTH-1:0]   a_mag, b_mag, sum;
    logic               cout;
    assign a_mag = (signed_mode_i && a_i[WIDTH-1]) ? ~a_i + WIDTH'(1) : a_i;
    assign b_mag = (signed_mode_i && b_i[WIDTH-1]) ? ~b_i + WIDTH'(1) : b_i;
    // Upper half accumulates; lower half holds the multiplier, consumed LSB first.
    ripple_adder #(.WIDTH(WIDTH)) u_add (
        .a_i    (acc_q[2*WIDTH-1:WIDTH]),
        .b_i    (acc_q[0] ? mcand_q : '0),
        .sum_o  (sum),
        .cout_o (cout)
    );
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        neg_d     = neg_q;
        product_d = product_q;
        done_d    = 1'b0;
        if (state_q == IDLE && start_i) begin
            mcand_d = a_mag;
            acc_d   = {{WIDTH{1'b0}}, b_mag};
            neg_d   = signed_mode_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            cnt_d   = '0;
            state_d = RUN;
        end else if (state_q == RUN) begin
            acc_d   = {cout, sum, acc_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CW'(1);
            state_d = (cnt_q == CW'(WIDTH - 1)) ? FINISH : RUN;
        end else if (state_q == FINISH) begin
            product_d = neg_q ? ~acc_q + (2*WIDTH)'(1) : acc_q;
            done_d    = 1'b1;
            state_d   = IDLE;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            neg_q     <= 1'b0;
            product_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            neg_q     <= neg_d;
            product_q <= product_d;
            done_q    <= done_d;
        end
    end
    assign busy_o    = (state_q != IDLE);
    assign done_o    = done_q;
    assign product_o = product_q;
endmodule

// File: tb/tb_seq_array_multiplier.sv
// tb_seq_array_multiplier: directed checks of the 8-bit multiplier plus exhaustive 2-bit operand sweep.
module tb_seq_array_multiplier;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start8, signed8, busy8, done8;
    logic [7:0]  a8, b8;
    logic [15:0] product8;
    logic        start2, signed2, busy2, done2;
    logic [1:0]  a2, b2;
    logic [3:0]  product2;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    seq_array_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start_i(start8), .signed_mode_i(signed8),
        .a_i(a8), .b_i(b8), .busy_o(busy8), .done_o(done8), .product_o(product8)
    );
    seq_array_multiplier #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start_i(start2), .signed_mode_i(signed2),
        .a_i(a2), .b_i(b2), .busy_o(busy2), .done_o(done2), .product_o(product2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives start for one edge; returns at #1 after the accepting edge.
    task automatic launch8(input logic s, input logic [7:0] x, input logic [7:0] y);
        signed8 = s; a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic wait_done8(output int n, output int nb);
        n = 0; nb = 0;
        do begin
            @(posedge clk); #1;
            n++;
            if (busy8) nb++;
        end while (!done8 && n < 20);
    endtask

    task automatic mul8(input string tag, input logic s, input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] exp);
        int n, nb;
        launch8(s, x, y);
        check({tag, " busy@start"}, 32'(busy8), 32'd1);
        wait_done8(n, nb);
        check({tag, " latency"}, 32'(n), 32'd9);
        check({tag, " product"}, 32'(product8), 32'(exp));
    endtask

    initial begin
        int n, nb, dcnt;
        rst_n = 1'b0;
        start8 = 1'b0; signed8 = 1'b0; a8 = '0; b8 = '0;
        start2 = 1'b0; signed2 = 1'b0; a2 = '0; b2 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst busy8", 32'(busy8), 32'd0);
        check("rst done8", 32'(done8), 32'd0);
        check("rst product8", 32'(product8), 32'd0);
        check("rst product2", 32'(product2), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 255 x 255 with full timing checks
        launch8(1'b0, 8'hFF, 8'hFF);
        check("ff*ff busy@start", 32'(busy8), 32'd1);
        wait_done8(n, nb);
        check("ff*ff latency", 32'(n), 32'd9);
        check("ff*ff busy cycles", 32'(nb), 32'd8);
        check("ff*ff busy@done", 32'(busy8), 32'd0);
        check("ff*ff product", 32'(product8), 32'h0000FE01);
        @(posedge clk); #1;
        check("ff*ff done pulse", 32'(done8), 32'd0);
        check("ff*ff held", 32'(product8), 32'h0000FE01);

        mul8("s -128*-128", 1'b1, 8'h80, 8'h80, 16'h4000);
        mul8("s -3*5", 1'b1, 8'hFD, 8'h05, 16'hFFF1);
        mul8("s 127*-1", 1'b1, 8'h7F, 8'hFF, 16'hFF81);
        mul8("u fd*5", 1'b0, 8'hFD, 8'h05, 16'h04F1);
        mul8("s fd*5", 1'b1, 8'hFD, 8'h05, 16'hFFF1);
        mul8("s 0*-5", 1'b1, 8'h00, 8'hFB, 16'h0000);
        mul8("u 12*34", 1'b0, 8'h12, 8'h34, 16'h03A8);

        // start pulses and operand changes mid-run are ignored
        launch8(1'b0, 8'h12, 8'h34);
        repeat (3) @(posedge clk);
        #1;
        start8 = 1'b1; signed8 = 1'b1; a8 = 8'hFF; b8 = 8'h80;
        repeat (2) @(posedge clk);
        #1;
        start8 = 1'b0; a8 = 8'h55; b8 = 8'hAA;
        wait_done8(n, nb);
        check("ignore latency", 32'(n), 32'd4);
        check("ignore product", 32'(product8), 32'h000003A8);
        // start in the done cycle is accepted
        launch8(1'b0, 8'd7, 8'd6);
        check("b2b busy", 32'(busy8), 32'd1);
        check("b2b held", 32'(product8), 32'h000003A8);
        wait_done8(n, nb);
        check("b2b latency", 32'(n), 32'd9);
        check("b2b product", 32'(product8), 32'd42);

        // async reset during iteration 4 aborts
        launch8(1'b1, 8'hFD, 8'h05);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort busy", 32'(busy8), 32'd0);
        check("abort done", 32'(done8), 32'd0);
        check("abort product", 32'(product8), 32'd0);
        #1;
        rst_n = 1'b1;
        dcnt = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (done8) dcnt++;
        end
        check("abort no done", 32'(dcnt), 32'd0);
        mul8("after abort 127*-1", 1'b1, 8'h7F, 8'hFF, 16'hFF81);

        // WIDTH=2 exhaustive sweep against an integer reference
        for (int s = 0; s < 2; s++) begin
            for (int x = 0; x < 4; x++) begin
                for (int y = 0; y < 4; y++) begin
                    int ax, by, m;
                    logic [3:0] exp2;
                    ax = (s == 1 && x > 1) ? x - 4 : x;
                    by = (s == 1 && y > 1) ? y - 4 : y;
                    exp2 = 4'(ax * by);
                    signed2 = 1'(s); a2 = 2'(x); b2 = 2'(y); start2 = 1'b1;
                    @(posedge clk); #1;
                    start2 = 1'b0;
                    m = 0;
                    do begin
                        @(posedge clk); #1;
                        m++;
                    end while (!done2 && m < 10);
                    check($sformatf("w2 s%0d %0d*%0d latency", s, x, y), 32'(m), 32'd3);
                    check($sformatf("w2 s%0d %0d*%0d product", s, x, y), 32'(product2), 32'(exp2));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/seq_array_multiplier.md
# seq_array_multiplier

Parametrised sequential shift-add multiplier. It is the successor to the team's fixed 2x2 combinational array multiplier. It multiplies two WIDTH-bit operands, unsigned or two's-complement selected per operation, over WIDTH+1 clock cycles, using one WIDTH-bit adder instead of a WIDTH² gate array. It sits on the datapath as a start/done coprocessor and holds its result until the next operation.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiply; sampled only while idle.
- signed_mode  input  1  1 = operands are two's complement, 0 = unsigned; sampled with start.
- a  input  WIDTH  multiplicand; sampled with start.
- b  input  WIDTH  multiplier; sampled with start.
- busy  output  1  operation in progress; start is ignored while high.
- done  output  1  one-cycle pulse; product is valid from this cycle on.
- product  output  2*WIDTH  result; held until the next accepted operation completes.

## Operation
- States: IDLE, RUN, FINISH.
- IDLE, start=1: capture the operands, go to RUN, clear the counter and the accumulator.
  - Unsigned mode: capture a and b as-is.
  - Signed mode: capture |a| and |b| as WIDTH-bit unsigned magnitudes. |−2^(WIDTH−1)| = 2^(WIDTH−1) fits, no overflow.
  - Capture neg = a[MSB] ^ b[MSB] when signed, otherwise neg = 0.
- RUN: one iteration per cycle, WIDTH cycles total, counter 0..WIDTH−1.
  - If the multiplier LSB is 1, add the multiplicand magnitude into the upper accumulator half. The adder carry-out becomes the new top bit.
  - Then shift the {carry, accumulator, multiplier} register right by 1.
  - At counter = WIDTH−1, go to FINISH.
- FINISH: load product with the 2*WIDTH-bit accumulator, negated (two's complement) if neg = 1. Pulse done. Go to IDLE.
- start while busy: ignored, with no effect on the operation in flight. Operand changes during RUN have no effect.
- start high in the cycle done is high: accepted, since the block is already IDLE. Back-to-back throughput is one result per WIDTH+1 cycles.
- Zero operands need no special case. A zero magnitude gives product 0 regardless of neg.
- Worst-case signed result: (−2^(W−1))² = 2^(2W−2). It fits in 2*WIDTH signed; no saturation logic.

## Timing
- Reset (async assert, synchronous release at clk): state = IDLE, busy = 0, done = 0, product = 0, all internal registers cleared.
- Reset mid-operation aborts immediately. No done is produced, and product returns to 0.
- Start sampled at edge k. busy is 1 from edge k to edge k+WIDTH+1.
- Iterations occur at edges k+1 … k+WIDTH.
- At edge k+WIDTH+1: product is updated, done = 1 for exactly one cycle, busy = 0.
- Latency from start edge to valid product: WIDTH+1 cycles.
- done, busy and product are registered outputs, with no combinational path from inputs.

## Structure
- Shared package mult_pkg: the state enum type (IDLE, RUN, FINISH) and the default WIDTH localparam.
- One sub-module: ripple_adder #(WIDTH), a WIDTH-bit adder with carry-out built from full-adder cells, instantiated once for the accumulate step.
- Negation and magnitude conversion are inline in the top level (invert plus increment).

## Test plan
- WIDTH=8, unsigned: 255×255 → product 0xFE01, done exactly 9 cycles after the start edge, busy high for those 9 cycles.
- WIDTH=8, signed: −128×−128 → 0x4000; −3×5 → 0xFFF1; 127×−1 → 0xFF81.
- WIDTH=8, unsigned: 0xFD×5 → 0x04F1. The same operands in signed mode → −15 = 0xFFF1.
- WIDTH=8: start pulses and operand changes during RUN are ignored and the result is unchanged.
  - A new start in the done cycle is accepted, and its result follows 9 cycles later.
- rst_n pulsed low at iteration 4 → busy, done and product go to 0 at once, no done appears, and the next start completes correctly.
- WIDTH=2: exhaustive 16 operand pairs in both modes, compared against a reference model; unsigned results must match the 2x2 array multiplier truth table.
